ifu_axi_fetch: RTL and testbench

Parametrised instruction-fetch unit that replaces the fixed single-register fetch stage. It issues AXI-lite reads to instruction memory, extracts the 32-bit instruction from a wider data beat, and buffers {pc, inst, err} in a DEPTH-entry FIFO toward IDU. Jump and interrupt redirects flush the buffer and discard any in-flight response. It sits between the core redirect sources (EXU/CSR) and IDU.

---
 rtl/ifu_axi_fetch.sv | 127 ++++++++++++
 tb/tb_ifu_axi_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_fetch.sv
// Instruction fetch unit: single-outstanding AXI-lite reads into a DEPTH-entry
// {pc, inst, err} FIFO toward IDU, with jump/interrupt redirect and flush.
module ifu_axi_fetch #(
   parameter int              PC_W     = 64,
   parameter int              ADDR_W   = 32,
   parameter int              DATA_W   = 64,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = 'h8000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              intr_valid,
   input  logic [PC_W-1:0]   intr_pc,
   input  logic              jump_valid,
   input  logic [PC_W-1:0]   jump_pc,
   output logic              arvalid,
   output logic [ADDR_W-1:0] araddr,
   input  logic              arready,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   output logic              rready,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst_o,
   output logic [PC_W-1:0]   pc_o,
   output logic              err_o
);
   localparam int WORDS = DATA_W / 32;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   fetch_pc, fetch_pc_nxt;
   logic              drop, drop_nxt;
   logic [CNT_W-1:0]  count, count_after;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PC_W-1:0]   fifo_pc   [DEPTH];
   logic [31:0]       fifo_inst [DEPTH];
   logic              fifo_err  [DEPTH];
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;
   logic              r_hs, push, pop;
   logic [31:0]       word;

   generate
      if (WORDS == 1) begin : g_one_word
         assign word = rdata[31:0];
      end else begin : g_word_sel
         logic [$clog2(WORDS)-1:0] idx;
         assign idx  = fetch_pc[$clog2(WORDS)+1:2];
         assign word = rdata[32*idx +: 32];
      end
   endgenerate

   assign redirect    = intr_valid | jump_valid;
   assign redirect_pc = intr_valid ? intr_pc : jump_pc;
   assign r_hs        = (state == DATA) & rvalid;
   // A redirect discards the beat in flight and blocks the same-cycle pop
   assign push        = r_hs & ~drop & ~redirect;
   assign pop         = inst_valid & inst_ready & ~redirect;

   assign arvalid    = (state == ADDR);
   assign rready     = (state == DATA);
   assign inst_valid = (count != '0);
   assign inst_o     = fifo_inst[rd_ptr];
   assign pc_o       = fifo_pc[rd_ptr];
   assign err_o      = fifo_err[rd_ptr];

   always_comb begin
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      drop_nxt     = drop;
      count_after  = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
      case (state)
         IDLE:    if (!redirect && count < FULL) state_nxt = ADDR;
         ADDR:    if (arready) state_nxt = DATA;
         DATA:    if (rvalid) state_nxt = (count_after < FULL) ? ADDR : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (push) fetch_pc_nxt = fetch_pc + PC_W'(4);
      if (redirect) begin
         fetch_pc_nxt = redirect_pc;
         if (state != IDLE) drop_nxt = 1'b1;
      end
      // The outstanding read finishing always clears drop, even on a new redirect
      if (r_hs) drop_nxt = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC;
         drop     <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         araddr   <= RESET_PC[ADDR_W-1:0];
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pc[i]   <= '0;
            fifo_inst[i] <= '0;
            fifo_err[i]  <= 1'b0;
         end
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         drop     <= drop_nxt;
         count    <= count_after;
         if (state_nxt == ADDR && state != ADDR) araddr <= fetch_pc_nxt[ADDR_W-1:0];
         if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) begin
               fifo_pc[wr_ptr]   <= fetch_pc;
               fifo_inst[wr_ptr] <= word;
               fifo_err[wr_ptr]  <= (rresp != 2'b00);
               wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_ifu_axi_fetch.sv
// Directed bench for ifu_axi_fetch: AXI-lite memory model, output monitor,
// expected-entry tables and hand-written redirect/stall sequences.
module tb_ifu_axi_fetch;
   logic        clk = 1'b0;
   logic        rst;
   logic        intr_valid, jump_valid;
   logic [63:0] intr_pc, jump_pc;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        inst_valid, inst_ready, err_o;
   logic [31:0] inst_o;
   logic [63:0] pc_o;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        err;
   } ent_t;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
      logic        err;
      int          cyc;
   } obs_t;

   int total = 0;
   int bad   = 0;

   // memory model knobs, written only by the main sequence
   bit          fixed_cfg;
   int          r_lat_cfg;
   int          ar_stall_cfg;
   logic [31:0] err_addr_cfg;

   logic [31:0] ar_q[$];
   obs_t        out_q[$];
   ent_t        exp_q[$];
   int          cyc;

   ifu_axi_fetch dut (
      .clk(clk), .rst(rst),
      .intr_valid(intr_valid), .intr_pc(intr_pc),
      .jump_valid(jump_valid), .jump_pc(jump_pc),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_o(inst_o), .pc_o(pc_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   // AXI-lite slave: acts on negedges, sees the handshakes of the following posedge
   initial begin
      logic        ar_hs, r_hs, pend;
      logic [31:0] ar_cap, pend_addr, base;
      int          r_left, stall_left;
      ar_hs = 0; r_hs = 0; pend = 0; ar_cap = '0; pend_addr = '0;
      r_left = 0; stall_left = 0;
      arready = 0; rvalid = 0; rdata = '0; rresp = 2'b00;
      forever begin
         @(negedge clk);
         if (rst) begin
            arready = 0; rvalid = 0; rresp = 2'b00;
            ar_hs = 0; r_hs = 0; pend = 0; r_left = 0;
            stall_left = ar_stall_cfg;
            ar_q.delete();
         end else begin
            if (r_hs) begin
               rvalid = 0; rresp = 2'b00; pend = 0;
            end
            if (ar_hs) begin
               pend = 1; pend_addr = ar_cap; r_left = r_lat_cfg;
               ar_q.push_back(ar_cap);
            end
            if (pend && !rvalid) begin
               if (r_left == 0) begin
                  base   = {pend_addr[31:3], 3'b000};
                  rvalid = 1;
                  rdata  = fixed_cfg ? 64'hAAAA_BBBB_1111_2222 : {base + 32'd4, base};
                  rresp  = (pend_addr == err_addr_cfg) ? 2'b10 : 2'b00;
               end else begin
                  r_left--;
               end
            end
            arready = arvalid && (stall_left == 0);
            if (arvalid && stall_left > 0) stall_left--;
            ar_hs  = arvalid && arready;
            ar_cap = araddr;
            r_hs   = rvalid && rready;
         end
      end
   end

   initial begin
      cyc = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) out_q.delete();
         else if (inst_valid && inst_ready) out_q.push_back('{pc_o, inst_o, err_o, cyc});
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic wait_q(input int n_out, input int n_ar, input string nm);
      int k;
      k = 0;
      while ((out_q.size() < n_out || ar_q.size() < n_ar) && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      total++;
      if (k >= 400) begin
         bad++;
         $display("FAIL %s_timeout: got outs=%0d ars=%0d expected outs=%0d ars=%0d",
                  nm, out_q.size(), ar_q.size(), n_out, n_ar);
      end
   endtask

   task automatic cmp_outs(input string nm);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < out_q.size()) begin
            chk($sformatf("%s_pc%0d", nm, i),   out_q[i].pc,         exp_q[i].pc);
            chk($sformatf("%s_inst%0d", nm, i), 64'(out_q[i].inst),  64'(exp_q[i].inst));
            chk($sformatf("%s_err%0d", nm, i),  64'(out_q[i].err),   64'(exp_q[i].err));
         end else begin
            total++; bad++;
            $display("FAIL %s_missing%0d: got %0d entries expected %0d", nm, i, out_q.size(), exp_q.size());
         end
      end
   endtask

   // leaves the bench at posedge+1 with rst still high
   task automatic do_reset(input bit fixed, input int lat, input int stall, input logic [31:0] eaddr, input logic rdy);
      @(posedge clk); #1;
      rst = 1; fixed_cfg = fixed; r_lat_cfg = lat; ar_stall_cfg = stall; err_addr_cfg = eaddr;
      inst_ready = rdy; intr_valid = 0; jump_valid = 0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      rst = 1; inst_ready = 0; intr_valid = 0; jump_valid = 0;
      intr_pc = '0; jump_pc = '0;
      fixed_cfg = 0; r_lat_cfg = 0; ar_stall_cfg = 0; err_addr_cfg = 32'hFFFF_FFFF;

      // reset values, then release timing
      do_reset(1, 0, 0, 32'hFFFF_FFFF, 1);
      chk("rst_arvalid",    64'(arvalid),    0);
      chk("rst_rready",     64'(rready),     0);
      chk("rst_araddr",     64'(araddr),     64'h8000_0000);
      chk("rst_inst_valid", 64'(inst_valid), 0);
      chk("rst_inst",       64'(inst_o),     0);
      chk("rst_pc",         pc_o,            0);
      chk("rst_err",        64'(err_o),      0);
      rst = 0;
      @(negedge clk);
      chk("rel_idle_arvalid", 64'(arvalid), 0);
      @(posedge clk); #1;
      chk("rel_next_arvalid", 64'(arvalid), 1);

      // zero-wait memory, fixed beat: word select by pc[2]
      exp_q.delete();
      exp_q.push_back('{64'h8000_0000, 32'h1111_2222, 1'b0});
      exp_q.push_back('{64'h8000_0004, 32'hAAAA_BBBB, 1'b0});
      wait_q(2, 2, "zw");
      cmp_outs("zw");
      chk("zw_ar0", 64'(ar_q[0]), 64'h8000_0000);
      chk("zw_ar1", 64'(ar_q[1]), 64'h8000_0004);
      if (out_q.size() >= 2) chk("zw_rate", 64'(out_q[1].cyc - out_q[0].cyc), 2);

      // IDU stalled: FIFO fills to DEPTH and fetch idles
      do_reset(0, 0, 0, 32'hFFFF_FFFF, 0);
      rst = 0;
      repeat (20) @(posedge clk);
      #1;
      chk("full_ars",        64'(ar_q.size()),  4);
      chk("full_outs",       64'(out_q.size()), 0);
      chk("full_arvalid",    64'(arvalid),      0);
      chk("full_rready",     64'(rready),       0);
      chk("full_inst_valid", 64'(inst_valid),   1);
      chk("full_head_pc",    pc_o,              64'h8000_0000);
      inst_ready = 1;
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         logic [31:0] p;
         p = 32'h8000_0000 + 32'(4 * i);
         exp_q.push_back('{64'(p), p, 1'b0});
      end
      wait_q(5, 5, "drain");
      cmp_outs("drain");
      chk("drain_resume_ar", 64'(ar_q[4]), 64'h8000_0010);

      // jump while waiting in DATA: response dropped
      do_reset(0, 3, 0, 32'hFFFF_FFFF, 1);
      rst = 0;
      k = 0;
      while (!rready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      chk("jmp_in_data", 64'(rready), 1);
      jump_valid = 1; jump_pc = 64'h8000_1000;
      @(posedge clk); #1;
      jump_valid = 0;
      chk("jmp_fifo_empty", 64'(inst_valid), 0);
      chk("jmp_arvalid_held", 64'(arvalid), 0);
      exp_q.delete();
      exp_q.push_back('{64'h8000_1000, 32'h8000_1000, 1'b0});
      wait_q(1, 2, "jmp");
      cmp_outs("jmp");
      chk("jmp_ar0", 64'(ar_q[0]), 64'h8000_0000);
      chk("jmp_ar1", 64'(ar_q[1]), 64'h8000_1000);

      // interrupt beats jump in the same cycle
      do_reset(0, 0, 0, 32'hFFFF_FFFF, 1);
      rst = 0;
      intr_valid = 1; intr_pc = 64'h8000_0100;
      jump_valid = 1; jump_pc = 64'h8000_2000;
      @(posedge clk); #1;
      intr_valid = 0; jump_valid = 0;
      exp_q.delete();
      exp_q.push_back('{64'h8000_0100, 32'h8000_0100, 1'b0});
      wait_q(1, 1, "prio");
      cmp_outs("prio");
      chk("prio_ar0", 64'(ar_q[0]), 64'h8000_0100);

      // bus error on 0x80000008 is delivered and fetch continues
      do_reset(0, 0, 0, 32'h8000_0008, 1);
      rst = 0;
      exp_q.delete();
      exp_q.push_back('{64'h8000_0000, 32'h8000_0000, 1'b0});
      exp_q.push_back('{64'h8000_0004, 32'h8000_0004, 1'b0});
      exp_q.push_back('{64'h8000_0008, 32'h8000_0008, 1'b1});
      exp_q.push_back('{64'h8000_000C, 32'h8000_000C, 1'b0});
      wait_q(4, 4, "err");
      cmp_outs("err");

      // AR stalled while redirect asserted: address phase stays put
      do_reset(0, 0, 6, 32'hFFFF_FFFF, 1);
      rst = 0;
      k = 0;
      while (!arvalid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         jump_valid = (i < 2); jump_pc = 64'h8000_3000;
         chk($sformatf("stall_arvalid%0d", i), 64'(arvalid), 1);
         chk($sformatf("stall_araddr%0d", i),  64'(araddr),  64'h8000_0000);
         @(posedge clk); #1;
      end
      jump_valid = 0;
      exp_q.delete();
      exp_q.push_back('{64'h8000_3000, 32'h8000_3000, 1'b0});
      wait_q(1, 2, "stall");
      cmp_outs("stall");
      chk("stall_ar0", 64'(ar_q[0]), 64'h8000_0000);
      chk("stall_ar1", 64'(ar_q[1]), 64'h8000_3000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
